// File: rtl/score_keeper.sv
// score_keeper: rhythm-game round scorer.
//   Watches NUM_LANES dropper lanes for hit edges (score_in rising) and
//   miss edges (drop_end rising while score_in is low), and keeps hit/miss
//   counts, the current and best combo and the point total for one round of
//   ROUND_FRAMES frames.
// Ports:
//   frame_clk   - clock, rising edge
//   Reset       - asynchronous active-high reset
//   keycode     - 8'h2c starts a round (Idle), 8'h01 returns to Idle (Done)
//   score_in    - per-lane hit level
//   drop_end    - per-lane "dropper reached End" level
//   total_score - accumulated points (saturating)
//   hit_count, miss_count, combo, max_combo - saturating 10-bit counters
//   round_state - 0 Idle, 1 Play, 2 Done
// Build option: define SCORE_KEEPER_COMBO_BONUS_EN to award +5 per hit while
//   the running combo (before that hit) is 10 or more.

module score_keeper_lane (
  input  logic score,
  input  logic score_prev,
  input  logic drop,
  input  logic drop_prev,
  output logic hit,
  output logic miss
);
  assign hit  = score & ~score_prev;
  // A drop reaching End on a lane that is already scored is not a miss.
  assign miss = drop & ~drop_prev & ~score;
endmodule

module score_keeper #(
  parameter int NUM_LANES    = 8,
  parameter int ROUND_FRAMES = 3000
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [NUM_LANES-1:0] score_in,
  input  logic [NUM_LANES-1:0] drop_end,
  output logic [15:0]          total_score,
  output logic [9:0]           hit_count,
  output logic [9:0]           miss_count,
  output logic [9:0]           combo,
  output logic [9:0]           max_combo,
  output logic [1:0]           round_state
);
  localparam int FW = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(ROUND_FRAMES - 1);
  localparam logic [31:0] CNT_MAX   = 32'd1023;
  localparam logic [31:0] SCORE_MAX = 32'd65535;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [FW-1:0]        frame_cnt;
  logic [NUM_LANES-1:0] score_prev, drop_prev;
  logic [NUM_LANES-1:0] hit, miss;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    score_keeper_lane u_lane (
      .score      (score_in[i]),
      .score_prev (score_prev[i]),
      .drop       (drop_end[i]),
      .drop_prev  (drop_prev[i]),
      .hit        (hit[i]),
      .miss       (miss[i])
    );
  end

  // Per-cycle event tally and next counter values (all in 32 bits, clamped).
  logic [31:0] n_hit, n_miss, combo_base, combo_sum, score_add;
  logic [31:0] hit_sum, miss_sum, score_sum;
  logic [9:0]  combo_new, hit_new, miss_new, max_new;
  logic [15:0] score_new;
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
  logic [31:0] run;
`endif

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_hit  = n_hit  + 32'(hit[i]);
      n_miss = n_miss + 32'(miss[i]);
    end
    // Misses are applied before hits: any miss breaks the run first.
    combo_base = (n_miss != 0) ? 32'd0 : 32'(combo);
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
    // Hits are walked in ascending lane order so each sees the combo left
    // by the lower lanes before it.
    run       = combo_base;
    score_add = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit[i]) begin
        score_add = score_add + ((run >= 32'd10) ? 32'd15 : 32'd10);
        if (run < CNT_MAX) run = run + 32'd1;
      end
    end
`else
    score_add = n_hit * 32'd10;
`endif
    combo_sum = combo_base + n_hit;
    hit_sum   = 32'(hit_count) + n_hit;
    miss_sum  = 32'(miss_count) + n_miss;
    score_sum = 32'(total_score) + score_add;
    combo_new = (combo_sum > CNT_MAX) ? 10'h3ff : combo_sum[9:0];
    hit_new   = (hit_sum   > CNT_MAX) ? 10'h3ff : hit_sum[9:0];
    miss_new  = (miss_sum  > CNT_MAX) ? 10'h3ff : miss_sum[9:0];
    score_new = (score_sum > SCORE_MAX) ? 16'hffff : score_sum[15:0];
    max_new   = (combo_new > max_combo) ? combo_new : max_combo;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (keycode == 8'h2c) state_nxt = PLAY;
      PLAY:    if (frame_cnt == LAST_FRAME) state_nxt = DONE;
      DONE:    if (keycode == 8'h01) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      score_prev  <= '0;
      drop_prev   <= '0;
      total_score <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      state      <= state_nxt;
      // Edge history follows the inputs in every state, so levels that
      // changed while idle are not seen as edges once play starts.
      score_prev <= score_in;
      drop_prev  <= drop_end;
      if (state == IDLE && state_nxt == PLAY) begin
        frame_cnt   <= '0;
        total_score <= '0;
        hit_count   <= '0;
        miss_count  <= '0;
        combo       <= '0;
        max_combo   <= '0;
      end else if (state == PLAY) begin
        frame_cnt   <= frame_cnt + FW'(1);
        total_score <= score_new;
        hit_count   <= hit_new;
        miss_count  <= miss_new;
        combo       <= combo_new;
        max_combo   <= max_new;
      end
    end
  end

  assign round_state = state;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;
  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [7:0]  score_in;
  logic [7:0]  drop_end;
  logic [15:0] total_score;
  logic [9:0]  hit_count, miss_count, combo, max_combo;
  logic [1:0]  round_state;

  int checks = 0;
  int failures = 0;

  score_keeper #(.NUM_LANES(8), .ROUND_FRAMES(50)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .score_in    (score_in),
    .drop_end    (drop_end),
    .total_score (total_score),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .combo       (combo),
    .max_combo   (max_combo),
    .round_state (round_state)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0] key;
    logic [7:0] si;
    logic [7:0] de;
    logic [1:0] st;
    int h, m, c, mc, sc;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input int h,
                     input int m, input int c, input int mc, input int sc);
    checks++;
    if (round_state !== st || hit_count !== 10'(h) || miss_count !== 10'(m) ||
        combo !== 10'(c) || max_combo !== 10'(mc) || total_score !== 16'(sc)) begin
      failures++;
      $display("FAIL %s: got st=%0d hit=%0d miss=%0d combo=%0d max=%0d score=%0d, want st=%0d hit=%0d miss=%0d combo=%0d max=%0d score=%0d",
               nm, round_state, hit_count, miss_count, combo, max_combo, total_score,
               st, h, m, c, mc, sc);
    end
  endtask

  int exp12;

  initial begin
    vt[0]  = '{8'h2c, 8'h00, 8'h00, 2'd1, 0, 0, 0, 0, 0};
    vt[1]  = '{8'h00, 8'h01, 8'h00, 2'd1, 1, 0, 1, 1, 10};
    vt[2]  = '{8'h00, 8'h07, 8'h00, 2'd1, 3, 0, 3, 3, 30};
    vt[3]  = '{8'h00, 8'h27, 8'h00, 2'd1, 4, 0, 4, 4, 40};
    vt[4]  = '{8'h00, 8'h37, 8'h08, 2'd1, 5, 1, 1, 4, 50};
    vt[5]  = '{8'h00, 8'h37, 8'h08, 2'd1, 5, 1, 1, 4, 50};
    vt[6]  = '{8'h00, 8'h37, 8'h09, 2'd1, 5, 1, 1, 4, 50};
    vt[7]  = '{8'h00, 8'h00, 8'h09, 2'd1, 5, 1, 1, 4, 50};
    vt[8]  = '{8'h00, 8'h01, 8'h09, 2'd1, 6, 1, 2, 4, 60};
    vt[9]  = '{8'h00, 8'h01, 8'h0B, 2'd1, 6, 2, 0, 4, 60};
    vt[10] = '{8'h00, 8'h05, 8'h0F, 2'd1, 7, 2, 1, 4, 70};
    vt[11] = '{8'h01, 8'h05, 8'h0F, 2'd1, 7, 2, 1, 4, 70};

    Reset = 1'b1; keycode = 8'h00; score_in = 8'h00; drop_end = 8'h00;
    #12;
    chk("reset_state", 2'd0, 0, 0, 0, 0, 0);
    step();
    Reset = 1'b0;

    // Round 1: table of hit/miss patterns.
    for (int i = 0; i < 12; i++) begin
      keycode = vt[i].key; score_in = vt[i].si; drop_end = vt[i].de;
      step();
      chk($sformatf("vec%0d", i), vt[i].st, vt[i].h, vt[i].m, vt[i].c, vt[i].mc, vt[i].sc);
    end

    // Asynchronous reset mid-play with hit_count=7.
    #3 Reset = 1'b1;
    #1 chk("async_reset", 2'd0, 0, 0, 0, 0, 0);
    step();
    keycode = 8'h00; score_in = 8'h00; drop_end = 8'h00;
    Reset = 1'b0;

    // Round 2: first edge after reset release starts play; run to Done.
    keycode = 8'h2c;
    step();
    chk("start_after_reset", 2'd1, 0, 0, 0, 0, 0);
    keycode = 8'h00;
    for (int i = 0; i < 49; i++) step();
    chk("last_play_frame", 2'd1, 0, 0, 0, 0, 0);
    score_in = 8'h01;
    step();
    chk("round_end", 2'd2, 1, 0, 1, 1, 10);
    score_in = 8'h03; drop_end = 8'h04;
    step();
    chk("done_ignores", 2'd2, 1, 0, 1, 1, 10);
    keycode = 8'h01;
    step();
    chk("done_to_idle", 2'd0, 1, 0, 1, 1, 10);
    keycode = 8'h00; score_in = 8'h83; drop_end = 8'h0C;
    step();
    chk("idle_ignores", 2'd0, 1, 0, 1, 1, 10);

    // Round 3: held levels are not edges; then 12 single hits.
    keycode = 8'h2c;
    step();
    chk("start_clears", 2'd1, 0, 0, 0, 0, 0);
    keycode = 8'h00; drop_end = 8'h00;
    step();
    chk("history_captured", 2'd1, 0, 0, 0, 0, 0);
    score_in = 8'h00;
    step();
    for (int k = 0; k < 12; k++) begin
      score_in = 8'(1 << (k % 8));
      step();
    end
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
    exp12 = 130;
`else
    exp12 = 120;
`endif
    chk("combo12", 2'd1, 12, 0, 12, 12, exp12);
    drop_end = 8'h01;
    step();
    chk("miss_resets_combo", 2'd1, 12, 1, 0, 12, exp12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 8, giving the number of dropper lanes monitored.
REQ-002 The block SHALL have parameter ROUND_FRAMES, default 3000, giving the round length in frame_clk cycles.
REQ-003 The block SHALL have port frame_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port keycode, input, 8, the primary key: 8'h2c starts a round, 8'h01 returns to idle.
REQ-006 The block SHALL have port score_in, input, NUM_LANES, per-lane hit level, held high by a dropper after a hit.
REQ-007 The block SHALL have port drop_end, input, NUM_LANES, per-lane level, high once a dropper reaches End.
REQ-008 The block SHALL have port total_score, output, 16, the accumulated points.
REQ-009 The block SHALL have port hit_count, output, 10, the number of hits.
REQ-010 The block SHALL have port miss_count, output, 10, the number of misses.
REQ-011 The block SHALL have port combo, output, 10, the current run of consecutive hits.
REQ-012 The block SHALL have port max_combo, output, 10, the largest combo this round.
REQ-013 The block SHALL have port round_state, output, 2, where 0=Idle, 1=Play, 2=Done.

Function
REQ-014 The block SHALL implement FSM Idle->Play when keycode==8'h2c, Play->Done when the frame counter reaches ROUND_FRAMES-1, and Done->Idle when keycode==8'h01; all other conditions hold the current state.
REQ-015 On the Idle->Play transition, the block SHALL clear all counters, combo, max_combo, total_score and the frame counter, and SHALL capture the edge-detect history to the current inputs.
REQ-016 In Play, the block SHALL increment the frame counter (width ceil(log2(ROUND_FRAMES))) by 1 every cycle.
REQ-017 A lane hit SHALL be a 0->1 transition of score_in[i] between consecutive cycles.
REQ-018 A lane miss SHALL be a 0->1 transition of drop_end[i] with score_in[i]==0 in the same cycle.
REQ-019 A drop_end rise with score_in high SHALL count as nothing extra.
REQ-020 For H hits and M misses in one cycle, hit_count SHALL increase by H and miss_count by M, with outputs registered one cycle after the input edge.
REQ-021 Simultaneous hits and misses in one cycle SHALL be processed as misses first, then hits: if M>0, combo SHALL become H; else combo SHALL become combo+H.
REQ-022 max_combo SHALL update to the new combo in the same cycle whenever the new combo exceeds it.
REQ-023 total_score SHALL increase by 10 per hit.
REQ-024 All counters SHALL saturate at their all-ones value and never wrap.
REQ-025 Edges arriving in Idle or Done SHALL be ignored for counting, but the edge-detect history SHALL still be tracked every cycle.
REQ-026 All outputs SHALL hold their values in Done until the Done->Idle transition.
REQ-027 On the Done->Idle transition, all outputs SHALL hold their values; they clear only on the next Idle->Play transition.

Reset
REQ-028 On Reset high, the block SHALL asynchronously set state=Idle, all counters, combo, max_combo, total_score and edge history to 0, and round_state to 0.
REQ-029 Reset asserted mid-Play SHALL abort the round immediately, with no further counting until a new start.
REQ-030 After Reset deassertion, the first rising edge SHALL evaluate normally.

Configuration
REQ-031 The block SHALL support macro SCORE_KEEPER_COMBO_BONUS_EN.
REQ-032 When SCORE_KEEPER_COMBO_BONUS_EN is defined, each hit SHALL score 10 plus 5 if the combo value before that hit is >=10, with hits within one cycle evaluated in ascending lane order.
REQ-033 When SCORE_KEEPER_COMBO_BONUS_EN is undefined, each hit SHALL score a flat 10 and the bonus logic SHALL be absent.

Verification
REQ-034 Reset, then keycode=8'h2c for one cycle, then score_in[0] 0->1 -> one cycle later round_state=1, hit_count=1, combo=1, total_score=10.
REQ-035 In Play, score_in[1] and score_in[2] rise together -> hit_count +2, combo +2, total_score +20 in one cycle.
REQ-036 combo=4, then drop_end[3] rises with score_in[3]=0 while score_in[4] rises -> miss_count +1, combo=1, max_combo=4.
REQ-037 ROUND_FRAMES=50, 8'h2c, wait 50 cycles, then edges on score_in -> round_state=2 and counters unchanged; keycode=8'h01 -> round_state=0 with values retained.
REQ-038 Assert Reset asynchronously mid-Play with hit_count=7 -> all outputs 0 before the next clock edge.
REQ-039 With SCORE_KEEPER_COMBO_BONUS_EN defined, 12 single hits on consecutive cycles -> total_score=10*10+2*15=130, combo=12.
